// File: rtl/sdram_wr_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// sdram_wr_burst_ctrl_if
//
// Bundles every non-clock, non-reset signal of sdram_wr_burst_ctrl: the read
// port of the upstream my_fifo, the flush/busy control pair and the write-burst
// handshake to the SDRAM controller.
//
// Modports
//   master : the burst controller (drives fifo_rd_en, sdram_wr_req/addr/len/
//            data and busy; receives FIFO data, flush and controller strobes)
//   slave  : the surrounding logic (FIFO + SDRAM controller + flush source)
//
// Parameters
//   DATA_W : FIFO / SDRAM data word width
//   ADDR_W : SDRAM word-address width
//   LEN_W  : burst length field width, log2(BURST_LEN)+1
// -----------------------------------------------------------------------------
interface sdram_wr_burst_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 4
);

  // my_fifo read port
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_empty;

  // control
  logic              flush;
  logic              busy;

  // SDRAM controller write-burst port
  logic              sdram_wr_req;
  logic              sdram_wr_ack;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [LEN_W-1:0]  sdram_wr_len;
  logic              sdram_wr_data_req;
  logic [DATA_W-1:0] sdram_wr_data;
  logic              sdram_wr_done;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    input  flush,
    output busy,
    output sdram_wr_req,
    input  sdram_wr_ack,
    output sdram_wr_addr,
    output sdram_wr_len,
    input  sdram_wr_data_req,
    output sdram_wr_data,
    input  sdram_wr_done
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    output flush,
    input  busy,
    input  sdram_wr_req,
    output sdram_wr_ack,
    input  sdram_wr_addr,
    input  sdram_wr_len,
    output sdram_wr_data_req,
    input  sdram_wr_data,
    output sdram_wr_done
  );

endinterface

// File: rtl/sdram_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_wr_burst_ctrl
//
// Write-path stage sitting on the read port of my_fifo, in the SDRAM write
// clock domain. Words are drained from the FIFO into a single local buffer of
// BURST_LEN entries. When the buffer is full (or when a flush asks for a
// partial burst) one write-burst request is raised to the SDRAM controller;
// the buffered words are then streamed out, one per controller data strobe.
// Once the controller reports the burst committed, the write address advances
// by the burst length and wraps back to ADDR_BASE when a full burst would no
// longer fit below ADDR_END.
//
// Ports
//   clk   : single clock (same as my_fifo rd_clk)
//   rst_n : asynchronous active-low reset; abandons any burst in progress
//   bus   : sdram_wr_burst_ctrl_if.master
//             fifo_rd_en / fifo_rd_data / fifo_rd_empty  FIFO read port,
//               data valid the cycle after fifo_rd_en
//             flush            one-cycle pulse: send buffered partial burst
//             busy             low only while filling with an empty buffer
//             sdram_wr_req     level request, held until sdram_wr_ack
//             sdram_wr_addr    burst start address
//             sdram_wr_len     burst word count (1..BURST_LEN)
//             sdram_wr_data_req / sdram_wr_data  one word per strobe cycle
//             sdram_wr_done    one-cycle pulse: burst committed
//
// Parameters
//   DATA_W, ADDR_W      : data and address widths
//   BURST_LEN           : words per full burst, power of two, 2..256
//   ADDR_BASE, ADDR_END : write region [ADDR_BASE, ADDR_END), size a multiple
//                         of BURST_LEN
// -----------------------------------------------------------------------------
module sdram_wr_burst_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 24,
  parameter int                BURST_LEN = 8,
  parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(24'h000000),
  parameter logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(24'h000100)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_wr_burst_ctrl_if.master bus
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam int AW1   = ADDR_W + 1;

  localparam logic [LEN_W-1:0] FULL      = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [AW1-1:0]   BURST_AW1 = AW1'(BURST_LEN);

  typedef enum logic [1:0] {
    FILL,
    REQ,
    XFER,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // issued : FIFO reads launched in this fill
  // wcnt   : words actually captured into the buffer (also the burst length)
  // rcnt   : words handed to the controller in this burst
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  wcnt;
  logic [LEN_W-1:0]  rcnt;
  logic [ADDR_W-1:0] addr;
  logic              flush_pend;
  logic              rd_pend;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] burst_buf [BURST_LEN];

  logic              rd_en;
  logic              last_land;
  logic              flush_go;
  logic              flush_drop;
  logic              strobe;
  logic              last_strobe;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx_nxt;
  logic [AW1-1:0]    addr_sum;
  logic [AW1-1:0]    addr_reach;
  logic [ADDR_W-1:0] addr_nxt;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  // A read launched last cycle lands now; the one that fills the buffer ends
  // the fill on the same edge it is captured.
  assign last_land  = (state == FILL) && rd_pend && (wcnt == FULL - LEN_ONE);

  // Flush only acts once nothing is in flight (issued == wcnt), so the last
  // word read before the flush is never lost.
  assign flush_go   = (state == FILL) && flush_pend && (issued == wcnt) && (wcnt != '0);
  assign flush_drop = (state == FILL) && flush_pend && (issued == wcnt) && (wcnt == '0);

  // Strobes beyond the burst length are ignored.
  assign strobe      = (state == XFER) && bus.sdram_wr_data_req && (rcnt < wcnt);
  assign last_strobe = strobe && (rcnt == wcnt - LEN_ONE);

  assign wr_idx     = wcnt[IDX_W-1:0];
  assign rd_idx_nxt = rcnt[IDX_W-1:0] + IDX_W'(1);

  // Next burst start; wrap when a full burst would cross ADDR_END. One extra
  // bit keeps the comparison free of overflow near the top of the space.
  assign addr_sum   = {1'b0, addr} + AW1'(wcnt);
  assign addr_reach = addr_sum + BURST_AW1;
  assign addr_nxt   = (addr_reach > {1'b0, ADDR_END}) ? ADDR_BASE : addr_sum[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of block evaluation order.
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first; any path that skipped it would infer a
    // latch to hold the old value.
    state_nxt = state;
    unique case (state)
      FILL:      if (last_land || flush_go) state_nxt = REQ;
      REQ:       if (bus.sdram_wr_ack)      state_nxt = XFER;
      XFER:      if (last_strobe)           state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.sdram_wr_done)     state_nxt = FILL;
      default:                              state_nxt = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // rst_n gates the read strobe so a non-empty FIFO is not popped while the
    // block is held in reset.
    rd_en = rst_n && (state == FILL) && !bus.fifo_rd_empty &&
            (issued < FULL) && !flush_pend;
    bus.fifo_rd_en   = rd_en;
    bus.sdram_wr_req = (state == REQ);
    bus.busy         = !((state == FILL) && (wcnt == '0));
  end

  assign bus.sdram_wr_addr = addr;
  assign bus.sdram_wr_len  = wcnt;
  assign bus.sdram_wr_data = data_q;

  // ---------------------------------------------------------------------------
  // Counters, address, flush bookkeeping and output data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued     <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      addr       <= ADDR_BASE;
      flush_pend <= 1'b0;
      rd_pend    <= 1'b0;
      data_q     <= '0;
    end else begin
      rd_pend <= rd_en;

      if (rd_en)   issued <= issued + LEN_ONE;
      if (rd_pend) wcnt   <= wcnt + LEN_ONE;

      // Leaving FILL consumes any pending flush, including one that arrives
      // together with the last word of a full burst.
      if ((state == FILL) && (state_nxt != FILL)) begin
        flush_pend <= 1'b0;
      end else if (bus.flush) begin
        flush_pend <= 1'b1;
      end else if (flush_drop) begin
        flush_pend <= 1'b0;
      end

      if ((state == REQ) && bus.sdram_wr_ack) begin
        rcnt   <= '0;
        data_q <= burst_buf[0];
      end

      if (strobe) begin
        rcnt <= rcnt + LEN_ONE;
        // After the last word the output holds rather than showing a stale
        // buffer slot.
        if (!last_strobe) data_q <= burst_buf[rd_idx_nxt];
      end

      if ((state == WAIT_DONE) && bus.sdram_wr_done) begin
        addr   <= addr_nxt;
        wcnt   <= '0;
        issued <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; its contents are only read after being
  // written in the current fill, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (rd_pend) burst_buf[wr_idx] <= bus.fifo_rd_data;
  end

endmodule

// File: doc/sdram_wr_burst_ctrl.md
Name: sdram_wr_burst_ctrl

Overview:
Write-path stage directly downstream of my_fifo's read port, in the SDRAM write clock domain. Drains the FIFO into a local burst buffer of BURST_LEN words. Issues one write-burst request per full buffer, or per partial buffer on flush, to the SDRAM controller. Streams buffered words on the controller's data-request strobe and advances a wrapping write address after each burst.

Parameters:
DATA_W, 32, data word width (matches my_fifo rd_data)
ADDR_W, 24, SDRAM word-address width
BURST_LEN, 8, words per full burst; power of two, 2..256
ADDR_BASE, 24'h000000, first address of write region
ADDR_END, 24'h000100, one past last address of region; (ADDR_END-ADDR_BASE) is a multiple of BURST_LEN

Ports:
clk  in  1  single clock, same as my_fifo rd_clk
rst_n  in  1  asynchronous active-low reset
fifo_rd_en  out  1  read strobe to my_fifo
fifo_rd_data  in  DATA_W  my_fifo read data, valid the cycle after fifo_rd_en
fifo_rd_empty  in  1  my_fifo empty flag
flush  in  1  one-cycle pulse: send buffered partial burst
sdram_wr_req  out  1  burst request, level, held until ack
sdram_wr_ack  in  1  one-cycle request accept from controller
sdram_wr_addr  out  ADDR_W  burst start address, stable while req high
sdram_wr_len  out  log2(BURST_LEN)+1  burst word count, 1..BURST_LEN
sdram_wr_data_req  in  1  controller pulls one word per high cycle
sdram_wr_data  out  DATA_W  current buffer word
sdram_wr_done  in  1  one-cycle pulse: burst committed to SDRAM
busy  out  1  high in any state except FILL with zero buffered words

Behaviour:
- Reset (async, rst_n=0): state FILL, all counters 0, addr=ADDR_BASE. Outputs: fifo_rd_en=0, sdram_wr_req=0, sdram_wr_len=0, sdram_wr_data=0, busy=0. Buffer contents are don't-care. Reset mid-burst abandons the burst. No request is reissued.
- States: FILL, REQ, XFER, WAIT_DONE.
- FILL:
  - fifo_rd_en = !fifo_rd_empty && (issued < BURST_LEN) && !flush_pend. This is combinational from registered state and the empty flag.
  - issued increments on every rd_en.
  - One cycle after each rd_en, fifo_rd_data is written to buf[wcnt] and wcnt increments.
  - Go to REQ when wcnt reaches BURST_LEN (captured, not merely issued).
- flush:
  - Sampled in any state into flush_pend. Cleared when leaving FILL.
  - In FILL with flush_pend: no new rd_en. Once the in-flight read has landed (issued==wcnt), go to REQ if wcnt>0. If wcnt==0, clear flush_pend and stay in FILL.
  - Flush pulsed in REQ/XFER/WAIT_DONE applies to the next FILL.
- REQ:
  - sdram_wr_req=1, sdram_wr_addr=addr, sdram_wr_len=wcnt.
  - On sdram_wr_ack: deassert req the next cycle and go to XFER with rcnt=0.
  - ack outside REQ is ignored.
- XFER:
  - sdram_wr_data = buf[rcnt], registered. The first word is valid on the cycle XFER is entered.
  - On each sdram_wr_data_req cycle rcnt increments and the next word is presented the following cycle.
  - After len strobes go to WAIT_DONE. Extra strobes are ignored and sdram_wr_data holds.
- WAIT_DONE:
  - On sdram_wr_done: addr_next = addr + len.
  - If addr_next + BURST_LEN > ADDR_END then addr = ADDR_BASE, else addr = addr_next.
  - wcnt=issued=0, go to FILL.
  - done outside WAIT_DONE is ignored.
- fifo_rd_en is never asserted outside FILL. No FIFO read occurs while a burst is outstanding (single buffer).
- Simultaneous: rd_en on the last word and flush in the same cycle → full-burst path, len=BURST_LEN, flush_pend cleared. fifo_rd_empty rising with a read in flight does not cancel the capture.

Test Plan:
- FIFO preloaded with words 1..8, BURST_LEN=8 → 8 rd_en cycles. Req with addr=0x000000, len=8. After ack, data_req held 8 cycles → sdram_wr_data 1..8 in order. done → addr 0x000008.
- 3 words in FIFO then flush pulse → req with len=3, data 1,2,3. After done, addr=0x000003.
- FIFO empty, flush pulse → no req, busy stays 0, addr unchanged.
- 32 full bursts with ADDR_END=0x100 → addresses 0x00,0x08,…,0xF8, then 0x00 on the 33rd burst.
- FIFO goes empty after word 5 for 20 cycles, then refills → no req until the 8th capture. Data 1..8 intact, rd_en low while empty.
- rst_n pulled low during XFER after 4 strobes → all outputs at reset values immediately. The next burst starts at ADDR_BASE with fresh FIFO data.
